axi_addr_sched: RTL
===================

Name: axi_addr_sched

Overview:
- Scheduler in front of the read/write address-transaction FIFO that feeds the AXI address-channel driver.
- Round-robin arbitrates NREQ requesters, each presenting one 97-bit address descriptor, into the single FIFO write port.
- Enforces a per-requester outstanding-transaction limit, credited back by completion returns.
- Provides a run/drain control FSM so software can quiesce the address path.

Parameters:
- NREQ, 4: number of requesters (2..8).
- REQ_W, 2: requester index width, clog2(NREQ); must be <= 7.
- MAX_OUTS, 8: maximum outstanding transactions per requester (1..255).
- CNT_W, 4: outstanding counter width; must hold MAX_OUTS.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- sched_en  in  1  1 = run, 0 = stop granting and drain
- req_valid  in  NREQ  per-requester descriptor valid
- req_data  in  NREQ*97  descriptors; requester i at [i*97 +: 97]; fields addr[63:0], id[71:64], len[74:72], size[77:75], tag[89:78]
- req_ready  out  NREQ  one-hot accept strobe
- addrtrans_fifo_full  in  1  address FIFO full
- addrtrans_fifo_wr  out  1  FIFO write strobe
- addrtrans_fifo_wrdata  out  97  descriptor written
- cpl_valid  in  1  one transaction completed
- cpl_req  in  REQ_W  requester owning the completion
- sched_state  out  2  00 IDLE, 01 RUN, 10 DRAIN
- drain_done  out  1  one-cycle pulse on DRAIN->IDLE
- cpl_err  out  1  sticky completion-underflow flag

Behaviour:
- Reset values:
  - state IDLE; all counters 0; rr pointer = NREQ-1, so requester 0 wins first.
  - req_ready=0, addrtrans_fifo_wr=0, drain_done=0, cpl_err=0.
- Eligibility: requester i is eligible when req_valid[i] && outs_cnt[i] < MAX_OUTS.
- Grant condition: state==RUN && !addrtrans_fifo_full && at least one eligible requester.
  - Winner: first eligible index searching upward from rr_ptr+1, wrapping modulo NREQ.
- Grant cycle (combinational, zero latency):
  - req_ready[winner]=1.
  - addrtrans_fifo_wr=1.
  - addrtrans_fifo_wrdata[89:0] = winner's req_data[89:0].
  - [90 +: REQ_W] = winner index; remaining upper bits 0.
  - req_ready/addrtrans_fifo_wr are never asserted while addrtrans_fifo_full=1.
- Registered on grant: rr_ptr <= winner; outs_cnt[winner] += 1.
- Requester handshake: descriptor is consumed on the cycle req_ready[i]=1; requester holds data stable while valid and not ready.
- Completion: cpl_valid decrements outs_cnt[cpl_req].
  - Same-cycle grant and completion for the same requester: count unchanged.
  - Completion when the count is 0: count stays 0 and cpl_err sets; cleared only by reset.
  - cpl_req >= NREQ: ignored and cpl_err sets.
- Counter never exceeds MAX_OUTS; a requester at MAX_OUTS is skipped with no grant bubble for the others.
- FSM (state register, sched_state mirrors it):
  - IDLE: no grants; sched_en=1 -> RUN.
  - RUN: grants per above; sched_en=0 -> DRAIN. The grant is suppressed in the cycle sched_en is sampled 0.
  - DRAIN: no grants; completions still counted.
    - sched_en=1 -> RUN (takes priority).
    - else all counters 0 (post-update) -> IDLE with drain_done=1 for exactly that cycle.
- Reset mid-operation: all state cleared asynchronously; in-flight counts are discarded. The system resets the downstream FIFO together with this block.

Test Plan:
- Reset, then sched_en=1 with all 4 req_valid held and FIFO never full.
  -> Grants 0,1,2,3,0,... one per cycle.
  -> wrdata[91:90] matches the index and wrdata[89:0] is passed through.
- Requester 2 only, MAX_OUTS=8, no completions.
  -> Exactly 8 grants, then req_ready[2]=0.
  -> One cpl_valid with cpl_req=2 -> exactly one further grant.
- addrtrans_fifo_full=1 for 5 cycles with requests pending.
  -> addrtrans_fifo_wr=0 and req_ready=0 throughout.
  -> The first grant after full drops goes to the next rr index.
- Same cycle: grant to requester 1 and cpl_valid/cpl_req=1 with count 3 -> count stays 3.
  - cpl_valid to requester 0 with count 0 -> cpl_err=1 and stays 1.
- Requester 3 holds 3 outstanding, sched_en dropped.
  -> State DRAIN, no grants.
  -> 3 completions -> drain_done pulses 1 cycle, state IDLE.
  -> Repeat with sched_en=1 raised mid-drain -> RUN, no drain_done.
- Assert reset during a RUN burst -> all outputs 0 the same cycle; state IDLE, counters 0, first post-reset grant to requester 0.

Source files
------------

// File: rtl/axi_addr_sched.sv
// axi_addr_sched: round-robin scheduler feeding the AXI address-transaction FIFO.
// Arbitrates NREQ requesters into the single FIFO write port. Each requester is
// limited to MAX_OUTS outstanding transactions, and each completion return
// credits one back. A run/drain FSM lets software quiesce the address path.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   sched_en               1 = run, 0 = stop granting and drain
//   req_valid/req_data     per-requester descriptor (97 bits each, requester i at [i*97 +: 97])
//   req_ready              one-hot accept strobe (combinational grant)
//   addrtrans_fifo_*       FIFO full input, write strobe and descriptor written
//   cpl_valid/cpl_req      completion return and owning requester
//   sched_state            00 IDLE, 01 RUN, 10 DRAIN
//   drain_done             one-cycle pulse, coincident with the first IDLE cycle after DRAIN
//   cpl_err                sticky completion-underflow / bad-index flag
module axi_addr_sched #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned REQ_W    = 2,
  parameter int unsigned MAX_OUTS = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sched_en,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*97-1:0]  req_data,
  output logic [NREQ-1:0]     req_ready,
  input  logic                addrtrans_fifo_full,
  output logic                addrtrans_fifo_wr,
  output logic [96:0]         addrtrans_fifo_wrdata,
  input  logic                cpl_valid,
  input  logic [REQ_W-1:0]    cpl_req,
  output logic [1:0]          sched_state,
  output logic                drain_done,
  output logic                cpl_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10
  } state_t;

  state_t           state;
  logic [REQ_W-1:0] rr_ptr;
  logic [CNT_W-1:0] outs_cnt [NREQ];
  logic [CNT_W-1:0] cnt_nxt  [NREQ];

  logic [NREQ-1:0]  eligible;
  logic [REQ_W-1:0] winner;
  logic             found;
  logic             grant;
  logic             err_evt;
  logic             all_zero_nxt;

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      eligible[i] = req_valid[i] && (outs_cnt[i] < CNT_W'(MAX_OUTS));
    end
  end

  // Search upward from rr_ptr+1, wrapping; first eligible index wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      int unsigned idx;
      idx = (32'(rr_ptr) + k) % NREQ;
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = REQ_W'(idx);
      end
    end
  end

  // sched_en gates the grant directly so no grant issues in the cycle it drops.
  assign grant = (state == RUN) && sched_en && !addrtrans_fifo_full && found;

  always_comb begin
    req_ready             = '0;
    addrtrans_fifo_wr     = 1'b0;
    addrtrans_fifo_wrdata = '0;
    if (grant) begin
      req_ready[winner]                 = 1'b1;
      addrtrans_fifo_wr                 = 1'b1;
      addrtrans_fifo_wrdata[89:0]       = req_data[32'(winner)*97 +: 90];
      addrtrans_fifo_wrdata[90 +: REQ_W] = winner;
    end
  end

  // Next outstanding counts; a grant and completion to the same requester cancel.
  always_comb begin
    err_evt      = cpl_valid && (32'(cpl_req) >= NREQ);
    all_zero_nxt = 1'b1;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cnt_nxt[i] = outs_cnt[i];
      if (cpl_valid && (32'(cpl_req) == i) && (outs_cnt[i] == '0)) begin
        err_evt = 1'b1;
      end
      if (grant && (32'(winner) == i) && !(cpl_valid && (32'(cpl_req) == i))) begin
        cnt_nxt[i] = outs_cnt[i] + CNT_W'(1);
      end else if (!(grant && (32'(winner) == i)) && cpl_valid && (32'(cpl_req) == i)
                   && (outs_cnt[i] != '0)) begin
        cnt_nxt[i] = outs_cnt[i] - CNT_W'(1);
      end
      if (cnt_nxt[i] != '0) begin
        all_zero_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= REQ_W'(NREQ - 1);
      drain_done <= 1'b0;
      cpl_err    <= 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) begin
        outs_cnt[i] <= '0;
      end
    end else begin
      drain_done <= 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) begin
        outs_cnt[i] <= cnt_nxt[i];
      end
      if (grant) begin
        rr_ptr <= winner;
      end
      if (err_evt) begin
        cpl_err <= 1'b1;
      end
      case (state)
        IDLE:  if (sched_en) state <= RUN;
        RUN:   if (!sched_en) state <= DRAIN;
        DRAIN: begin
          if (sched_en) begin
            state <= RUN;
          end else if (all_zero_nxt) begin
            state      <= IDLE;
            drain_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sched_state = state;

endmodule
